// File: rtl/pll_lock_sequencer_if.sv
// PLL lock sequencer signal bundle.
// slave: sequencer side (pll_locked/restart in; pll_rst, sys_rst_n,
//   ready, fault, retry_cnt out). master: the controlling side.
// PLL_LOCK_STATS_EN adds lock_loss_cnt and last_fault_retries.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
`ifdef PLL_LOCK_STATS_EN
  logic [7:0] lock_loss_cnt;
  logic [3:0] last_fault_retries;

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault,
    input  retry_cnt, lock_loss_cnt,
    input  last_fault_retries
  );

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault,
    output retry_cnt, lock_loss_cnt,
    output last_fault_retries
  );
`else
  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault,
    input  retry_cnt
  );

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault,
    output retry_cnt
  );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// Pixel-clock PLL bring-up sequencer, runs on the 50 MHz refclk.
// Ports: refclk, rst (async, active-low), bus (slave modport):
//   pll_locked (async raw), restart, pll_rst, sys_rst_n, ready,
//   fault, retry_cnt. Optional macro PLL_LOCK_STATS_EN adds
//   lock_loss_cnt and last_fault_retries.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input logic                  refclk,
  input logic                  rst,
  pll_lock_sequencer_if.slave  bus
);

  localparam int MAX_AB =
    (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC =
    (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] RP_LAST =
    CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX =
    4'(MAX_RETRIES);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [1:0]    sync_q;
  logic          lock_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          lost;
  logic          pll_rst_q, sys_rst_n_q;
  logic          ready_q, fault_q;
  logic          st_rst, st_wait, st_stab;
  logic          st_run, st_fault;

  assign lock_s   = sync_q[1];
  assign st_rst   = (state_q == S_RESET_PLL);
  assign st_wait  = (state_q == S_WAIT_LOCK);
  assign st_stab  = (state_q == S_STABILIZE);
  assign st_run   = (state_q == S_RUN);
  assign st_fault = (state_q == S_FAULT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    lost    = 1'b0;
    if (bus.restart) begin
      // restart wins over any transition this cycle
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (1'b1)
        st_rst: begin
          if (cnt_q == RP_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        st_wait: begin
          if (lock_s) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = S_RESET_PLL;
            end else begin
              state_d = S_FAULT;
            end
          end
        end
        st_stab: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == ST_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        st_run: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = S_RESET_PLL;
            lost    = 1'b1;
          end
        end
        st_fault: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move
  // on the same edge as the state register.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b00;
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.pll_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == S_RESET_PLL) ||
                     (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_LOCK_STATS_EN
  logic [7:0] loss_q;
  logic [3:0] last_q;
  logic       fault_entry;

  assign fault_entry = (state_d == S_FAULT) && !st_fault;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      loss_q <= '0;
      last_q <= '0;
    end else begin
      if (lost && (loss_q != 8'hFF))
        loss_q <= loss_q + 8'd1;
      if (fault_entry)
        last_q <= retry_q;
    end
  end

  assign bus.lock_loss_cnt      = loss_q;
  assign bus.last_fault_retries = last_q;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the pixel-clock PLL (50 MHz in, 25 MHz out) that feeds the VGA aquarium datapath.
- Drives the PLL reset and qualifies its lock indication.
- Holds the downstream video reset until lock has been stable for a programmed interval.
- Re-initialises the PLL on timeout or lock loss, up to a retry limit, then latches a fault.
- Runs entirely on the free-running 50 MHz reference, never on a PLL output.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronised lock required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK per attempt (>=1)
MAX_RETRIES, 3, re-attempts allowed after the first timeout before FAULT (0..15)

Ports:
refclk  in  1  50 MHz reference clock, free-running
rst  in  1  asynchronous active-low reset; 0 = reset asserted
pll_locked  in  1  raw PLL locked, asynchronous to refclk
restart  in  1  synchronous single-cycle request to re-run the full sequence
pll_rst  out  1  PLL reset, active-high
sys_rst_n  out  1  downstream video reset, active-low; consumers resynchronise into pixel domain
ready  out  1  1 while in RUN
fault  out  1  1 while in FAULT
retry_cnt  out  4  timeouts taken in the current bring-up attempt

Behaviour:
- Clock and reset: one clock, refclk. rst is asynchronous active-low.
- Reset values while rst=0:
  - state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, cycle counter=0
  - both synchroniser flops = 0
- pll_locked passes through a 2-flop synchroniser; lock_s is its output (2-cycle latency).
- All outputs are registered and update on the same edge as the state register.
- Single cycle counter, width $clog2(max of the three cycle parameters)+1. Cleared on every state entry.
- RESET_PLL: pll_rst=1, sys_rst_n=0. After RST_PULSE_CYCLES cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst_n=0.
  - lock_s=1: go to STABILIZE.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0:
    - if retry_cnt<MAX_RETRIES: retry_cnt+1, go to RESET_PLL
    - else: go to FAULT
- STABILIZE: pll_rst=0, sys_rst_n=0.
  - lock_s=0: go to WAIT_LOCK. The timeout counter restarts and retry_cnt is unchanged.
  - LOCK_STABLE_CYCLES consecutive cycles of lock_s=1: go to RUN.
- RUN: sys_rst_n=1, ready=1, retry_cnt cleared to 0 on entry.
  - lock_s=0: go to RESET_PLL. sys_rst_n=0 and pll_rst=1 on that edge.
  - Worst case from raw lock falling to sys_rst_n low is 3 refclk edges.
- FAULT: pll_rst=1 (PLL held in reset), sys_rst_n=0, fault=1. Left only by restart or rst.
- restart=1 in any state:
  - next edge goes to RESET_PLL, retry_cnt=0, fault=0
  - overrides every simultaneous transition (timeout, lock loss, stability completion)
- retry_cnt never exceeds MAX_RETRIES and never wraps.
- rst asserted mid-sequence: immediate asynchronous return to reset values. Sequencing restarts from RESET_PLL on the first edge after rst deasserts.
- Glitch rule: a lock_s low pulse of even one cycle in STABILIZE or RUN must be acted on. No filtering beyond the synchroniser.

Optional Feature:
PLL_LOCK_STATS_EN
- Defined:
  - Adds output lock_loss_cnt[7:0]: RUN-to-RESET_PLL transitions caused by lock_s=0, saturating at 255.
  - Adds output last_fault_retries[3:0]: retry_cnt value latched on FAULT entry.
  - Both reset to 0 by rst only; restart does not clear them.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up: release rst, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles after rst release; sys_rst_n=1, ready=1 exactly 8 cycles after lock_s first high; retry_cnt=0.
- Stability glitch: lock high, drop for 1 cycle on the 5th STABILIZE cycle -> back to WAIT_LOCK; ready only after 8 fresh consecutive lock_s cycles; retry_cnt unchanged.
- Timeout and fault: pll_locked held 0 -> three pll_rst pulses of 4 cycles each; retry_cnt steps 0,1,2; FAULT after the third 32-cycle wait; fault=1, pll_rst=1, sys_rst_n=0 held.
- Lock loss in RUN: reach RUN, drop pll_locked -> sys_rst_n low and pll_rst high within 3 edges; full sequence repeats. With PLL_LOCK_STATS_EN, lock_loss_cnt=1.
- Restart precedence: assert restart on the same cycle WAIT_LOCK times out with retry_cnt=2 -> RESET_PLL, not FAULT; retry_cnt=0, fault=0.
- Async reset mid-STABILIZE: pull rst low between edges -> outputs return to reset values immediately without a clock edge. With PLL_LOCK_STATS_EN, lock_loss_cnt=0.
